ndro_bank_sched: RTL and testbench
==================================

// Module: ndro_bank_sched
// PURPOSE
//  Sequencer/arbiter for a bank of N_CELLS NDRO cells (set/reset/clk in, out pulse back).
//  Arbitrates a write requester and a read requester for the bank, one access at a time.
//  Drives each cell pin as a toggle-encoded SFQ pulse: every level change is one pulse.
//  Enforces write-to-read settle time, then times the read window for the cell's out pulse.
//  Synchronous digital block on the conventional-clock side of the cell bank.
// PARAMETERS
//  N_CELLS    4  number of NDRO cells in the bank
//  IDX_W      2  cell index width; must satisfy 2**IDX_W >= N_CELLS
//  SETUP_CYC  2  cycles from a set/reset pulse to wr_ack; minimum 1
//  READ_WIN   3  cycles cell_out is watched after a clk pulse; minimum 1
// PORTS
//  clk        in   1        block clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  wr_req     in   1        write request; held high until wr_ack
//  wr_idx     in   IDX_W    target cell of the write
//  wr_data    in   1        1 = pulse set, 0 = pulse reset
//  wr_ack     out  1        one-cycle write completion
//  rd_req     in   1        read request; held high until rd_ack
//  rd_idx     in   IDX_W    target cell of the read
//  rd_ack     out  1        one-cycle read completion
//  rd_data    out  1        stored bit; valid only while rd_ack is high
//  busy       out  1        high in every state except IDLE
//  cell_set   out  N_CELLS  toggle-encoded set pulses, one bit per cell
//  cell_reset out  N_CELLS  toggle-encoded reset pulses, one bit per cell
//  cell_clk   out  N_CELLS  toggle-encoded readout clock pulses, one bit per cell
//  cell_out   in   N_CELLS  toggle-encoded out pulses from the cells
// BEHAVIOUR
//  Reset
//   - rst_n low clears all outputs and toggle registers to 0 and the FSM to IDLE.
//   - The RR pointer is cleared, so write has priority on the first contention.
//   - Reset returns the pulse lines to 0; the cells are reset alongside this block.
//  FSM: IDLE -> PULSE -> {SETTLE | WAIT_OUT} -> ACK -> IDLE
//  IDLE
//   - A request sampled high at cycle G is granted.
//   - op, idx and data are latched at G.
//   - If both requests are high, round-robin picks one; the pointer flips after each grant.
//  PULSE
//   - Exactly one toggle on cell_set[idx], cell_reset[idx] or cell_clk[idx].
//   - The toggle is visible at cycle T = G+1.
//   - No other pulse line changes.
//  Write
//   - SETTLE counts down.
//   - wr_ack is high for the single cycle T+SETUP_CYC.
//  Read
//   - cell_out[idx] is compared with its previous-cycle value in cycles T+1 .. T+READ_WIN.
//   - First change seen at T+k: rd_ack=1 and rd_data=1 at T+k+1.
//   - No change by T+READ_WIN: rd_ack=1 and rd_data=0 at T+READ_WIN+1.
//   - Extra toggles inside the window are absorbed; rd_data is not a count.
//  After ack
//   - The FSM returns to IDLE.
//   - The earliest next grant is the cycle after the ack.
//   - A requester keeping req high after its ack makes a new request.
//  Edge-tracking register
//   - The cell_out edge-tracking register updates every cycle for all cells.
//   - Toggles on unselected cells, or arriving outside a read window, are ignored.
//  Out-of-range index (idx >= N_CELLS)
//   - No pulse is issued.
//   - The ack is given at G+1; a read returns rd_data=0.
//  Request-line rules
//   - Changes to idx or data after G are ignored.
//   - A requester dropping req before its ack does not abort the access; the ack is still issued.
//  Reset mid-operation
//   - The access is abandoned and no ack is issued.
//   - A req still high after rst_n release is granted again as a new access.
// STRUCTURE
//  Package ndro_sched_pkg
//   - FSM state encoding: IDLE, PULSE, SETTLE, WAIT_OUT, ACK.
//   - Op encoding: OP_WR, OP_RD.
//   - Counter width: clog2(max(SETUP_CYC, READ_WIN) + 1).
//  Sub-module sfq_toggle_det
//   - N-bit registered toggle detector: change = cur ^ prev.
//   - Instantiated on cell_out.
//  Contents of ndro_bank_sched
//   - FSM, round-robin pointer, latched request fields, countdown counter.
//   - The three N-bit toggle output registers.
// TESTING
//  Common setup
//   - N_CELLS=4, SETUP_CYC=2, READ_WIN=3.
//   - Cell model: behavioural NDRO (set stores 1, reset stores 0, clk emits an out toggle if stored 1).
//  Directed scenarios
//   - Reset: rst_n=0 with random inputs -> all outputs 0 and busy=0. After release, one idle cycle -> still 0.
//   - Write: wr_req, idx=2, data=1 at G=0 -> cell_set[2] toggles at 1, wr_ack at 3 only, no other line moves.
//   - Read hit: after the write, rd idx=2 at G -> cell_clk[2] toggles at G+1, model out toggles at G+2 -> rd_ack and rd_data=1 at G+3.
//   - Read miss: rd idx=1 on a cell never set -> rd_ack at G+5 with rd_data=0.
//   - Contention: wr and rd both high after reset -> write granted first, read second. Repeat -> read granted first.
//   - Boundary and reset:
//     - N_CELLS=3, wr idx=3 -> wr_ack at G+1 with no toggles.
//     - rst_n pulsed low during WAIT_OUT -> no rd_ack; the held rd_req is regranted after release.

Source files
------------

// File: rtl/ndro_sched_pkg.sv
// Shared types and sizing helpers for the NDRO bank scheduler.
package ndro_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SETTLE,
        WAIT_OUT,
        ACK
    } state_t;

    typedef enum logic {
        OP_WR,
        OP_RD
    } op_t;

    // Countdown counter must hold the larger of the two timing parameters.
    function automatic int cnt_width(input int setup_cyc, input int read_win);
        int m;
        m = (setup_cyc > read_win) ? setup_cyc : read_win;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sfq_toggle_det.sv
// Registered toggle detector: flags every bit whose level differs from last cycle.
module sfq_toggle_det #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] cur,
    output logic [N-1:0] change
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= cur;
    end

    assign change = cur ^ prev_q;

endmodule

// File: rtl/ndro_bank_sched.sv
// Arbitrates write/read access to an NDRO cell bank and issues toggle-encoded pulses.
module ndro_bank_sched
    import ndro_sched_pkg::*;
#(
    parameter int N_CELLS   = 4,
    parameter int IDX_W     = 2,
    parameter int SETUP_CYC = 2,
    parameter int READ_WIN  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_data,
    output logic               wr_ack,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_ack,
    output logic               rd_data,
    output logic               busy,
    output logic [N_CELLS-1:0] cell_set,
    output logic [N_CELLS-1:0] cell_reset,
    output logic [N_CELLS-1:0] cell_clk,
    input  logic [N_CELLS-1:0] cell_out
);

    localparam int                CNT_W       = cnt_width(SETUP_CYC, READ_WIN);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETUP_CYC > 1) ? SETUP_CYC - 2 : 0);
    localparam logic [CNT_W-1:0]  WIN_LOAD    = CNT_W'(READ_WIN - 1);
    localparam logic [IDX_W:0]    N_LIM       = (IDX_W + 1)'(N_CELLS);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rr_q, rr_d;
    logic               rd_bit_q, rd_bit_d;
    logic [N_CELLS-1:0] set_q, reset_q, clk_q;
    logic [N_CELLS-1:0] set_tgl, reset_tgl, clk_tgl;
    logic [N_CELLS-1:0] change, g_sel, q_sel;
    logic               pick_wr, g_in_range;
    logic [IDX_W-1:0]   g_idx;

    sfq_toggle_det #(.N(N_CELLS)) u_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .cur    (cell_out),
        .change (change)
    );

    // rr_q = 0 favours the writer on contention.
    assign pick_wr    = wr_req & (~rd_req | ~rr_q);
    assign g_idx      = pick_wr ? wr_idx : rd_idx;
    assign g_in_range = ({1'b0, g_idx} < N_LIM);

    always_comb begin
        g_sel = '0;
        q_sel = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            g_sel[i] = (g_idx == IDX_W'(i));
            q_sel[i] = (idx_q == IDX_W'(i));
        end
    end

    // The pulse register flips on the grant edge so the toggle is visible in PULSE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        rd_bit_d  = rd_bit_q;
        set_tgl   = '0;
        reset_tgl = '0;
        clk_tgl   = '0;
        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    op_d     = pick_wr ? OP_WR : OP_RD;
                    idx_d    = g_idx;
                    rd_bit_d = 1'b0;
                    if (wr_req && rd_req) rr_d = ~rr_q;
                    if (g_in_range) begin
                        state_d = PULSE;
                        if (!pick_wr)     clk_tgl   = g_sel;
                        else if (wr_data) set_tgl   = g_sel;
                        else              reset_tgl = g_sel;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            PULSE: begin
                if (op_q == OP_WR) begin
                    if (SETUP_CYC > 1) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        state_d = ACK;
                    end
                end else begin
                    state_d = WAIT_OUT;
                    cnt_d   = WIN_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = ACK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WAIT_OUT: begin
                if (|(change & q_sel)) begin
                    rd_bit_d = 1'b1;
                    state_d  = ACK;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_WR;
            idx_q    <= '0;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            rd_bit_q <= 1'b0;
            set_q    <= '0;
            reset_q  <= '0;
            clk_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            rd_bit_q <= rd_bit_d;
            set_q    <= set_q ^ set_tgl;
            reset_q  <= reset_q ^ reset_tgl;
            clk_q    <= clk_q ^ clk_tgl;
        end
    end

    assign busy       = (state_q != IDLE);
    assign wr_ack     = (state_q == ACK) && (op_q == OP_WR);
    assign rd_ack     = (state_q == ACK) && (op_q == OP_RD);
    assign rd_data    = rd_ack & rd_bit_q;
    assign cell_set   = set_q;
    assign cell_reset = reset_q;
    assign cell_clk   = clk_q;

endmodule

// File: tb/tb_ndro_bank_sched.sv
// Scoreboard bench for ndro_bank_sched with a behavioural NDRO cell bank.
module tb_ndro_bank_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       wr_req = 0, wr_data = 0, rd_req = 0;
    logic [1:0] wr_idx = '0, rd_idx = '0;
    logic       wr_ack, rd_ack, rd_data, busy;
    logic [3:0] cell_set, cell_reset, cell_clk, cell_out;

    logic       wr_req3 = 0, wr_data3 = 0, rd_req3 = 0;
    logic [1:0] wr_idx3 = '0, rd_idx3 = '0;
    logic       wr_ack3, rd_ack3, rd_data3, busy3;
    logic [2:0] cell_set3, cell_reset3, cell_clk3;
    logic [2:0] cell_out3 = '0;

    ndro_bank_sched #(.N_CELLS(4), .IDX_W(2), .SETUP_CYC(2), .READ_WIN(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data),
        .busy(busy), .cell_set(cell_set), .cell_reset(cell_reset),
        .cell_clk(cell_clk), .cell_out(cell_out)
    );

    ndro_bank_sched #(.N_CELLS(3), .IDX_W(2), .SETUP_CYC(2), .READ_WIN(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req3), .wr_idx(wr_idx3), .wr_data(wr_data3), .wr_ack(wr_ack3),
        .rd_req(rd_req3), .rd_idx(rd_idx3), .rd_ack(rd_ack3), .rd_data(rd_data3),
        .busy(busy3), .cell_set(cell_set3), .cell_reset(cell_reset3),
        .cell_clk(cell_clk3), .cell_out(cell_out3)
    );

    // Behavioural NDRO bank: set stores 1, reset stores 0, clk emits an out toggle when stored.
    logic [3:0] stored, set_p, rst_p, clk_p, out_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored <= '0; set_p <= '0; rst_p <= '0; clk_p <= '0; out_m <= '0;
        end else begin
            set_p <= cell_set; rst_p <= cell_reset; clk_p <= cell_clk;
            for (int i = 0; i < 4; i++) begin
                if (cell_set[i] != set_p[i])        stored[i] <= 1'b1;
                else if (cell_reset[i] != rst_p[i]) stored[i] <= 1'b0;
                if ((cell_clk[i] != clk_p[i]) && stored[i]) out_m[i] <= ~out_m[i];
            end
        end
    end
    assign cell_out = out_m;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { bit is_wr; bit data; int at; } ack_t;
    typedef struct { int at; int kind; int idx; } pulse_t;   // kind 0=set 1=reset 2=clk
    ack_t   exp_q[$];
    pulse_t pulse_q[$];
    logic [3:0] exp_set = '0, exp_reset = '0, exp_clk = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic pulse_loop();
        forever begin
            @(posedge clk);
            #1;
            for (int i = pulse_q.size() - 1; i >= 0; i--) begin
                if (pulse_q[i].at == cyc) begin
                    case (pulse_q[i].kind)
                        0:       exp_set[pulse_q[i].idx]   = ~exp_set[pulse_q[i].idx];
                        1:       exp_reset[pulse_q[i].idx] = ~exp_reset[pulse_q[i].idx];
                        default: exp_clk[pulse_q[i].idx]   = ~exp_clk[pulse_q[i].idx];
                    endcase
                    pulse_q.delete(i);
                end
            end
        end
    endtask

    task automatic monitor_loop();
        ack_t e;
        forever begin
            @(negedge clk);
            chk("pulse_lines", {20'd0, cell_set, cell_reset, cell_clk},
                {20'd0, exp_set, exp_reset, exp_clk});
            if (wr_ack || rd_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack cyc=%0d wr_ack=%b rd_ack=%b want none", cyc, wr_ack, rd_ack);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_wr != wr_ack || e.is_wr == rd_ack || e.at != cyc ||
                        (!e.is_wr && rd_data != e.data)) begin
                        errors++;
                        $display("FAIL ack cyc=%0d got wr=%b rd=%b data=%b want wr=%b data=%b at cyc=%0d",
                                 cyc, wr_ack, rd_ack, rd_data, e.is_wr, e.data, e.at);
                    end
                end
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drop(input bit is_wr);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_wr ? wr_ack : rd_ack) && n < 30);
        if (!(is_wr ? wr_ack : rd_ack)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout is_wr=%b got no ack within 30 cycles want ack", is_wr);
        end
        next();
        if (is_wr) wr_req = 0; else rd_req = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_dut4"}, {21'd0, wr_ack, rd_ack, rd_data, busy, cell_set, cell_reset, cell_clk}, '0);
        chk({name, "_dut3"}, {19'd0, wr_ack3, rd_ack3, rd_data3, busy3, cell_set3, cell_reset3, cell_clk3}, '0);
    endtask

    task automatic do_reset();
        next();
        rst_n = 0;
        exp_set = '0; exp_reset = '0; exp_clk = '0;
        next();
        next();
        rst_n = 1;
    endtask

    initial begin
        int g;
        logic [31:0] r;
        fork
            pulse_loop();
            monitor_loop();
        join_none

        repeat (3) begin
            next();
            r = $urandom;
            wr_req = r[0]; rd_req = r[1]; wr_idx = r[3:2]; rd_idx = r[5:4]; wr_data = r[6];
            wr_req3 = r[7]; rd_req3 = r[8]; wr_idx3 = r[10:9]; rd_idx3 = r[12:11]; wr_data3 = r[13];
        end
        @(negedge clk);
        chk_zero("reset_outputs");
        next();
        wr_req = 0; rd_req = 0; wr_idx = '0; rd_idx = '0; wr_data = 0;
        wr_req3 = 0; rd_req3 = 0; wr_idx3 = '0; rd_idx3 = '0; wr_data3 = 0;
        rst_n = 1;
        @(negedge clk);
        chk_zero("idle_after_release");

        // Write set to cell 2; request fields scrambled after the grant.
        next(); g = cyc;
        wr_idx = 2; wr_data = 1; wr_req = 1;
        exp_q.push_back('{1'b1, 1'b0, g + 3});
        pulse_q.push_back('{g + 1, 0, 2});
        next();
        wr_idx = 0; wr_data = 0;
        wait_drop(1);

        // Read hit on cell 2.
        next(); g = cyc;
        rd_idx = 2; rd_req = 1;
        exp_q.push_back('{1'b0, 1'b1, g + 3});
        pulse_q.push_back('{g + 1, 2, 2});
        wait_drop(0);

        // Read miss on never-set cell 1.
        next(); g = cyc;
        rd_idx = 1; rd_req = 1;
        exp_q.push_back('{1'b0, 1'b0, g + 5});
        pulse_q.push_back('{g + 1, 2, 1});
        wait_drop(0);

        // Contention after reset: write wins, then read of the freshly set cell.
        do_reset();
        next(); g = cyc;
        wr_idx = 0; wr_data = 1; rd_idx = 0; wr_req = 1; rd_req = 1;
        exp_q.push_back('{1'b1, 1'b0, g + 3});
        exp_q.push_back('{1'b0, 1'b1, g + 7});
        pulse_q.push_back('{g + 1, 0, 0});
        pulse_q.push_back('{g + 5, 2, 0});
        fork
            wait_drop(1);
            wait_drop(0);
        join

        // Contention again: read wins (miss on cell 3), then reset pulse on cell 1.
        next(); g = cyc;
        wr_idx = 1; wr_data = 0; rd_idx = 3; wr_req = 1; rd_req = 1;
        exp_q.push_back('{1'b0, 1'b0, g + 5});
        exp_q.push_back('{1'b1, 1'b0, g + 9});
        pulse_q.push_back('{g + 1, 2, 3});
        pulse_q.push_back('{g + 7, 1, 1});
        fork
            wait_drop(0);
            wait_drop(1);
        join

        // Reset during WAIT_OUT: no ack, held request regranted after release.
        next(); g = cyc;
        rd_idx = 2; rd_req = 1;
        pulse_q.push_back('{g + 1, 2, 2});
        next();
        next();
        rst_n = 0;
        exp_set = '0; exp_reset = '0; exp_clk = '0;
        next();
        next();
        rst_n = 1; g = cyc;
        exp_q.push_back('{1'b0, 1'b0, g + 5});
        pulse_q.push_back('{g + 1, 2, 2});
        wait_drop(0);

        // Out-of-range index on the 3-cell instance.
        next();
        wr_idx3 = 3; wr_data3 = 1; wr_req3 = 1;
        @(negedge clk);
        chk("oor_wr_ack_at_g", {31'd0, wr_ack3}, 32'd0);
        next();
        @(negedge clk);
        chk("oor_wr_ack_at_g1", {31'd0, wr_ack3}, 32'd1);
        chk("oor_wr_no_pulse", {23'd0, cell_set3, cell_reset3, cell_clk3}, '0);
        next();
        wr_req3 = 0;
        @(negedge clk);
        chk("oor_wr_ack_one_cycle", {30'd0, wr_ack3, busy3}, 32'd0);
        next();
        rd_idx3 = 3; rd_req3 = 1;
        next();
        @(negedge clk);
        chk("oor_rd_ack", {30'd0, rd_ack3, rd_data3}, 32'd2);
        chk("oor_rd_no_pulse", {23'd0, cell_set3, cell_reset3, cell_clk3}, '0);
        next();
        rd_req3 = 0;

        repeat (5) next();
        chk("leftover_expected_acks", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
